pulse_capture: RTL

Measures an external digital waveform and makes the result readable by the CPU: the timer's counterpart in the reverse direction. The timer is written over `cs`/`wr`/`a0`/`di` and drives a waveform on `out`. This block takes a waveform on `cap_in`, measures its period and high time in `clk` cycles, and returns both over a `cs`/`rd`/`a0`/`do` read port. It sits beside the timer on the same peripheral bus and typically observes another timer's `out` or an external pin.

---
 rtl/pulse_capture_if.sv | 15 +
 rtl/pulse_capture.sv | 131 +++++++++++++
 2 files changed

// File: rtl/pulse_capture_if.sv
// Read-port bundle for pulse_capture: CPU-side strobes and the registered result/status lines.
// The read data line is named dout because do is a reserved word in SystemVerilog.
interface pulse_capture_if #(
  parameter int unsigned W = 16
) ();
  logic         cs;
  logic         rd;
  logic         a0;
  logic [W-1:0] dout;
  logic         rdy;
  logic         ovf;

  modport master (output cs, rd, a0, input dout, rdy, ovf);
  modport slave  (input cs, rd, a0, output dout, rdy, ovf);
endinterface

// File: rtl/pulse_capture.sv
// pulse_capture: measures period and high time of cap_in in clk cycles, read back over cs/rd/a0.
// Define PULSE_CAPTURE_SYNC_EN to add a two-flop synchronizer on cap_in (+2 cycles latency).
module pulse_capture #(
  parameter int unsigned CNT_W = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cap_in,
  pulse_capture_if.slave bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StHigh = 2'd1;
  localparam logic [1:0] StLow  = 2'd2;

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             s_cur;
  logic             s_prev_q;
  logic             rise;
  logic             fall;
  logic             rd_en;
  logic             latch;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] width_pend_q, width_pend_d;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] width_q;
  logic [CNT_W-1:0] dout_q;
  logic             sat_q, sat_d;
  logic             rdy_q;
  logic             ovf_q;

`ifdef PULSE_CAPTURE_SYNC_EN
  logic sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= cap_in;
      sync2_q <= sync1_q;
    end
  end

  assign s_cur = sync2_q;
`else
  assign s_cur = cap_in;
`endif

  assign rise  = s_cur & ~s_prev_q;
  assign fall  = ~s_cur & s_prev_q;
  assign rd_en = bus.cs & bus.rd;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    width_pend_d = width_pend_q;
    sat_d        = sat_q;
    latch        = 1'b0;
    case (state_q)
      StIdle: begin
        if (rise) begin
          state_d = StHigh;
          cnt_d   = CntOne;
        end
      end
      StHigh, StLow: begin
        // Saturate rather than wrap so an over-long phase reads as FFFF with ovf set.
        if (cnt_q == CntMax) begin
          sat_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
        if (state_q == StHigh && fall) begin
          state_d      = StLow;
          width_pend_d = cnt_q;
        end
        if (state_q == StLow && rise) begin
          state_d = StHigh;
          latch   = 1'b1;
          cnt_d   = CntOne;
          sat_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      s_prev_q     <= 1'b0;
      cnt_q        <= '0;
      width_pend_q <= '0;
      period_q     <= '0;
      width_q      <= '0;
      dout_q       <= '0;
      sat_q        <= 1'b0;
      rdy_q        <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      s_prev_q     <= s_cur;
      cnt_q        <= cnt_d;
      width_pend_q <= width_pend_d;
      sat_q        <= sat_d;
      // Period and width move together so the CPU never sees a mixed pair.
      if (latch) begin
        period_q <= cnt_q;
        width_q  <= width_pend_q;
        ovf_q    <= sat_q;
      end
      if (rd_en) begin
        dout_q <= bus.a0 ? width_q : period_q;
      end
      if (latch) begin
        rdy_q <= 1'b1;
      end else if (rd_en && !bus.a0) begin
        rdy_q <= 1'b0;
      end
    end
  end

  assign bus.dout = dout_q;
  assign bus.rdy  = rdy_q;
  assign bus.ovf  = ovf_q;

endmodule
